// File: rtl/pipe_tag_tracker.sv
// Destination-tag / tnew tracker for the EX, MEM and WB stages of a 5-stage pipe.
// Define MDU_BUSY_EN to add the multiply/divide busy countdown and its stall request.
module pipe_tag_tracker #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_a3,
  input  logic [1:0] id_tnew,
  input  logic       stall,
  input  logic       flush_ex_mem,
`ifdef MDU_BUSY_EN
  input  logic       id_md_start,
  input  logic       id_md_type,
  input  logic       id_md_use,
  output logic       md_busy,
  output logic       md_stall,
`endif
  output logic [4:0] ex_a3,
  output logic [4:0] mem_a3,
  output logic [4:0] wb_a3,
  output logic [1:0] ex_tnew,
  output logic [1:0] mem_tnew,
  output logic       ex_valid,
  output logic       mem_valid,
  output logic       wb_valid
);

  logic       ex_valid_q, ex_valid_d;
  logic [4:0] ex_a3_q, ex_a3_d;
  logic [1:0] ex_tnew_q, ex_tnew_d;
  logic       mem_valid_q, mem_valid_d;
  logic [4:0] mem_a3_q, mem_a3_d;
  logic [1:0] mem_tnew_q, mem_tnew_d;
  logic       wb_valid_q, wb_valid_d;
  logic [4:0] wb_a3_q, wb_a3_d;
  logic       id_writes;

  // An instruction without a real destination never has anything to forward.
  assign id_writes = id_valid && (id_a3 != 5'd0);

  always_comb begin
    ex_valid_d  = 1'b0;
    ex_a3_d     = 5'd0;
    ex_tnew_d   = 2'd0;
    mem_valid_d = 1'b0;
    mem_a3_d    = 5'd0;
    mem_tnew_d  = 2'd0;
    wb_valid_d  = mem_valid_q;
    wb_a3_d     = mem_a3_q;
    if (!stall) begin
      ex_valid_d = id_valid;
      ex_a3_d    = id_writes ? id_a3 : 5'd0;
      ex_tnew_d  = id_writes ? id_tnew : 2'd0;
    end
    if (!flush_ex_mem) begin
      mem_valid_d = ex_valid_q;
      mem_a3_d    = ex_a3_q;
      mem_tnew_d  = (ex_tnew_q != 2'd0) ? ex_tnew_q - 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_a3_q     <= 5'd0;
      ex_tnew_q   <= 2'd0;
      mem_valid_q <= 1'b0;
      mem_a3_q    <= 5'd0;
      mem_tnew_q  <= 2'd0;
      wb_valid_q  <= 1'b0;
      wb_a3_q     <= 5'd0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_a3_q     <= ex_a3_d;
      ex_tnew_q   <= ex_tnew_d;
      mem_valid_q <= mem_valid_d;
      mem_a3_q    <= mem_a3_d;
      mem_tnew_q  <= mem_tnew_d;
      wb_valid_q  <= wb_valid_d;
      wb_a3_q     <= wb_a3_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_a3     = ex_a3_q;
  assign ex_tnew   = ex_tnew_q;
  assign mem_valid = mem_valid_q;
  assign mem_a3    = mem_a3_q;
  assign mem_tnew  = mem_tnew_q;
  assign wb_valid  = wb_valid_q;
  assign wb_a3     = wb_a3_q;

`ifdef MDU_BUSY_EN
  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  logic [3:0] md_cnt_q, md_cnt_d;
  logic       md_busy_q, md_busy_d;
  logic       md_started_q, md_started_d;

  // A start accepted while busy simply reloads the countdown.
  always_comb begin
    md_started_d = id_md_start && !stall;
    md_cnt_d     = md_cnt_q;
    if (md_started_d) begin
      md_cnt_d = id_md_type ? DIV_LD : MULT_LD;
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
    md_busy_d = (md_cnt_d != 4'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q     <= 4'd0;
      md_busy_q    <= 1'b0;
      md_started_q <= 1'b0;
    end else begin
      md_cnt_q     <= md_cnt_d;
      md_busy_q    <= md_busy_d;
      md_started_q <= md_started_d;
    end
  end

  assign md_busy  = md_busy_q;
  // The start sitting in EX has not loaded the busy flag's consumers yet, so cover it too.
  assign md_stall = id_md_use && (md_busy_q || (ex_valid_q && md_started_q));
`endif

endmodule

// File: tb/tb_pipe_tag_tracker.sv
// Randomized scoreboard bench for pipe_tag_tracker; a stage-level reference model
// pushes the expected post-edge state, and a monitor compares it one cycle at a time.
module tb_pipe_tag_tracker;

`ifdef MDU_BUSY_EN
  localparam int W = 23;
`else
  localparam int W = 22;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_a3;
  logic [1:0] id_tnew;
  logic       stall;
  logic       flush_ex_mem;
  logic       id_md_start, id_md_type, id_md_use;
  logic       md_busy, md_stall;
  logic [4:0] ex_a3, mem_a3, wb_a3;
  logic [1:0] ex_tnew, mem_tnew;
  logic       ex_valid, mem_valid, wb_valid;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  string        cur_name = "reset";

  typedef struct packed {
    logic       v;
    logic [4:0] a3;
    logic [1:0] tn;
  } slot_t;

  slot_t m_ex, m_mem, m_wb;
  int    md_left;
  logic  md_start_last;

  always #5 clk = ~clk;

  pipe_tag_tracker #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_a3        (id_a3),
    .id_tnew      (id_tnew),
    .stall        (stall),
    .flush_ex_mem (flush_ex_mem),
`ifdef MDU_BUSY_EN
    .id_md_start  (id_md_start),
    .id_md_type   (id_md_type),
    .id_md_use    (id_md_use),
    .md_busy      (md_busy),
    .md_stall     (md_stall),
`endif
    .ex_a3        (ex_a3),
    .mem_a3       (mem_a3),
    .wb_a3        (wb_a3),
    .ex_tnew      (ex_tnew),
    .mem_tnew     (mem_tnew),
    .ex_valid     (ex_valid),
    .mem_valid    (mem_valid),
    .wb_valid     (wb_valid)
  );

`ifndef MDU_BUSY_EN
  assign md_busy  = 1'b0;
  assign md_stall = 1'b0;
`endif

  function automatic logic [W-1:0] pack_exp();
    logic [21:0] tags;
    tags = {m_ex.v, m_ex.a3, m_ex.tn, m_mem.v, m_mem.a3, m_mem.tn, m_wb.v, m_wb.a3};
`ifdef MDU_BUSY_EN
    return {md_left != 0, tags};
`else
    return tags;
`endif
  endfunction

  function automatic logic [W-1:0] pack_act();
    logic [21:0] tags;
    tags = {ex_valid, ex_a3, ex_tnew, mem_valid, mem_a3, mem_tnew, wb_valid, wb_a3};
`ifdef MDU_BUSY_EN
    return {md_busy, tags};
`else
    return tags;
`endif
  endfunction

  // Drive one cycle of inputs at the falling edge, advance the model, queue the expectation.
  task automatic step(input logic rst, input logic v, input logic [4:0] a3, input logic [1:0] tn,
                      input logic st, input logic fl, input logic ms = 1'b0,
                      input logic mt = 1'b0, input logic mu = 1'b0);
    logic writes;
    reset = rst; id_valid = v; id_a3 = a3; id_tnew = tn; stall = st; flush_ex_mem = fl;
    id_md_start = ms; id_md_type = mt; id_md_use = mu;
    #1;
`ifdef MDU_BUSY_EN
    checks++;
    if (md_stall !== (mu && (md_left != 0 || (m_ex.v && md_start_last)))) begin
      errors++;
      $display("FAIL md_stall[%s] got=%b want=%b", cur_name, md_stall,
               mu && (md_left != 0 || (m_ex.v && md_start_last)));
    end
`endif
    if (rst) begin
      m_ex = '0; m_mem = '0; m_wb = '0; md_left = 0; md_start_last = 1'b0;
    end else begin
      m_wb  = '{v: m_mem.v, a3: m_mem.a3, tn: 2'd0};
      m_mem = fl ? '0 : '{v: m_ex.v, a3: m_ex.a3, tn: (m_ex.tn == 0) ? 2'd0 : m_ex.tn - 2'd1};
      writes = v && (a3 != 0);
      m_ex  = st ? '0 : '{v: v, a3: writes ? a3 : 5'd0, tn: writes ? tn : 2'd0};
      if (ms && !st) md_left = mt ? 10 : 5;
      else if (md_left > 0) md_left--;
      md_start_last = ms && !st;
    end
    exp_q.push_back(pack_exp());
    name_q.push_back(cur_name);
    @(negedge clk);
  endtask

  // Monitor: every edge the DUT presents a new stage state; compare it against the queue head.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [W-1:0] e, a;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = pack_act();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL stages[%s] got=%h want=%h (ex v/a3/tn mem v/a3/tn wb v/a3)", n, a, e);
        end
      end
    end
  end

  initial begin
    m_ex = '0; m_mem = '0; m_wb = '0; md_left = 0; md_start_last = 1'b0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 9, 3, 1, 1);

    cur_name = "tag_flow";
    step(0, 1, 8, 2, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);

    cur_name = "stall_bubble";
    step(0, 1, 8, 2, 1, 0);
    step(0, 1, 8, 2, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);

    cur_name = "zero_dest";
    step(0, 1, 0, 2, 0, 0);
    step(0, 0, 7, 3, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);

    cur_name = "both_bubbles";
    step(0, 1, 5, 1, 0, 0);
    step(0, 1, 6, 2, 1, 1);
    repeat (3) step(0, 0, 0, 0, 0, 0);

    cur_name = "saturation";
    step(0, 1, 3, 0, 0, 0);
    step(0, 1, 31, 3, 0, 0);
    step(0, 1, 4, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);

    cur_name = "reset_mid";
    step(0, 1, 12, 3, 0, 0);
    step(0, 1, 13, 2, 0, 0);
    step(1, 1, 14, 1, 1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0);

    cur_name = "mdu_divide";
    step(0, 1, 2, 1, 0, 0, 1, 1, 0);
    repeat (12) step(0, 1, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 2, 1, 0, 0, 1, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 2, 1, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 1, 2, 1, 0, 0, 1, 1, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 1);

    cur_name = "random";
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
           5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
           $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    step(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_tag_tracker.md
PIPE_TAG_TRACKER -- requirements
Module: pipe_tag_tracker

Interface
REQ-001 Parameter MULT_CYCLES, default 5, EX-stage busy cycles for multiply.
REQ-002 Parameter DIV_CYCLES, default 10, EX-stage busy cycles for divide.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 id_valid  input  1  ID stage holds a real instruction.
REQ-006 id_a3  input  5  destination register of the ID instruction, 0 means no write.
REQ-007 id_tnew  input  2  cycles after entering EX until the result is forwardable.
REQ-008 stall  input  1  hazard stall: hold IF/ID, insert a bubble into EX.
REQ-009 flush_ex_mem  input  1  insert a bubble into MEM.
REQ-010 ex_a3 / mem_a3 / wb_a3  output  5 each  destination tag per stage.
REQ-011 ex_tnew / mem_tnew  output  2 each  remaining cycles until the value is ready, per stage.
REQ-012 ex_valid / mem_valid / wb_valid  output  1 each  stage holds a real instruction.
REQ-013 id_md_start  input  1  ID instruction starts a multiply/divide (present only with MDU_BUSY_EN).
REQ-014 id_md_type  input  1  0 = multiply, 1 = divide (MDU_BUSY_EN only).
REQ-015 id_md_use  input  1  ID instruction reads HI/LO or starts an MDU operation (MDU_BUSY_EN only).
REQ-016 md_busy  output  1  MDU countdown is nonzero (MDU_BUSY_EN only).
REQ-017 md_stall  output  1  stall request to the hazard unit (MDU_BUSY_EN only).

Function
REQ-018 All tag registers SHALL update only on the rising clk edge; all outputs SHALL be driven directly from registers, except md_stall, which is combinational.
REQ-019 ID to EX, with stall=0: ex_valid<=id_valid, ex_a3<=id_a3, ex_tnew<=id_tnew.
REQ-020 ID to EX, when id_valid=0 or id_a3=0: ex_a3<=0 and ex_tnew<=0 regardless of id_tnew.
REQ-021 ID to EX, with stall=1: EX SHALL load a bubble (valid 0, a3 0, tnew 0).
REQ-022 EX to MEM: mem_* <= ex_* with mem_tnew = ex_tnew-1, saturating at 0.
REQ-023 EX to MEM, with flush_ex_mem=1: MEM SHALL load a bubble instead.
REQ-024 MEM to WB: wb_valid<=mem_valid, wb_a3<=mem_a3 unconditionally; the WB value is always ready.
REQ-025 stall and flush_ex_mem both asserted: both bubbles SHALL be applied in the same cycle.
REQ-026 Latency: a tag presented at ID with stall=0 SHALL appear at ex_* 1 cycle later, mem_* 2 cycles later and wb_* 3 cycles later.
REQ-027 id_tnew value 3 SHALL be accepted and SHALL appear at MEM as 2.

Reset
REQ-028 With reset=1 at a clock edge, all *_valid, *_a3 and *_tnew SHALL be 0 and the MDU counter SHALL be 0, including mid-operation.
REQ-029 Reset SHALL take priority over stall, flush_ex_mem and id_md_start.

Configuration
REQ-030 Macro MDU_BUSY_EN SHALL compile in the MDU busy tracker.
REQ-031 With MDU_BUSY_EN, a 4-bit counter SHALL exist; on id_md_start=1 and stall=0 it SHALL load MULT_CYCLES (id_md_type=0) or DIV_CYCLES (id_md_type=1).
REQ-032 With MDU_BUSY_EN, the counter SHALL otherwise decrement by 1 per cycle while nonzero.
REQ-033 With MDU_BUSY_EN, a start accepted while busy SHALL reload the counter.
REQ-034 With MDU_BUSY_EN, md_busy = (counter != 0).
REQ-035 With MDU_BUSY_EN, md_stall = id_md_use and (md_busy, or ex_valid with an MDU start latched last cycle).
REQ-036 Without MDU_BUSY_EN, the MDU ports, counter and logic SHALL be absent; tag behaviour SHALL be unchanged.

Verification
REQ-037 Tag flow: reset, then id_valid=1, id_a3=8, id_tnew=2, stall=0 -> cycle+1 ex_a3=8/ex_tnew=2; cycle+2 mem_a3=8/mem_tnew=1; cycle+3 wb_a3=8, wb_valid=1.
REQ-038 Stall bubble: same tag with stall=1 for one cycle -> ex_valid=0, ex_a3=0 that cycle; tag enters EX the cycle after stall drops.
REQ-039 Zero destination: id_a3=0, id_tnew=2 -> ex_a3=0, ex_tnew=0.
REQ-040 Simultaneous bubbles: EX holds a3=5, stall=1 and flush_ex_mem=1 together -> ex_valid=0 and mem_valid=0 next cycle.
REQ-041 MDU_BUSY_EN divide: id_md_start=1, id_md_type=1 -> md_busy high for exactly 10 cycles; id_md_use=1 during that window -> md_stall=1; reset at cycle 4 -> md_busy=0 next cycle.
REQ-042 Saturation: id_tnew=0, a3=3 -> mem_tnew=0, no underflow.
